// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction fetch queue.
// Both channels use the same rule: a transfer happens on a rising edge where valid and ready are both high.
// Valid may not wait for ready.
// req_ready may depend on flush; out_valid depends only on stored state.
interface inst_fetch_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              req_valid;
    logic [PC_W-1:0]   req_pc;
    logic              req_ready;
    logic [INST_W-1:0] inst_sram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_adel;

    // master: the surrounding pipeline (IF, SRAM, ID); slave: the queue itself
    modport master (
        output req_valid, req_pc, inst_sram_rdata, out_ready,
        input  req_ready, out_valid, out_pc, out_inst, out_adel
    );

    modport slave (
        input  req_valid, req_pc, inst_sram_rdata, out_ready,
        output req_ready, out_valid, out_pc, out_inst, out_adel
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// IF->ID decoupling FIFO: credit-limited fetch requests, one-cycle SRAM response capture,
// in-order delivery of {pc, inst, adel} entries to decode, with flush support.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    inst_fetch_queue_if.slave          io,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              rsp_pending;
    logic [PC_W-1:0]   rsp_pc;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              adel_mem [DEPTH];

    logic [CNT_W:0]    credit_used;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic              rsp_adel;

    // An in-flight response already owns a slot, so the SRAM reply can never hit a full queue.
    assign credit_used  = {1'b0, count_q} + {{CNT_W{1'b0}}, rsp_pending};
    assign io.req_ready = rst & ~flush & (credit_used < DEPTH_C);
    assign req_fire     = io.req_valid & io.req_ready;

    assign head_valid   = (count_q != '0);
    assign push         = rsp_pending & ~flush;
    assign pop          = head_valid & io.out_ready & ~flush;
    assign rsp_adel     = (rsp_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rsp_pending <= 1'b0;
            rsp_pc      <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rsp_pending <= 1'b0;
        end else begin
            rsp_pending <= req_fire;
            if (req_fire) begin
                rsp_pc <= io.req_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is left unreset; every read is masked by head_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            inst_mem[wr_ptr] <= rsp_adel ? '0 : io.inst_sram_rdata;
            adel_mem[wr_ptr] <= rsp_adel;
        end
    end

    always_comb begin
        io.out_valid = head_valid;
        io.out_pc    = '0;
        io.out_inst  = '0;
        io.out_adel  = 1'b0;
        if (head_valid) begin
            io.out_pc   = pc_mem[rd_ptr];
            io.out_adel = adel_mem[rd_ptr];
            io.out_inst = adel_mem[rd_ptr] ? '0 : inst_mem[rd_ptr];
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, hand-written corner sequences,
// and a per-cycle queue-based reference model fed by random traffic.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = 65;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] count;

    inst_fetch_queue_if #(.PC_W(32), .INST_W(32)) io ();

    inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (io.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;

    function automatic logic [31:0] sram_word(input logic [31:0] pc);
        return pc ^ 32'hFFFF_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // SRAM model: data for a request accepted in cycle t is presented during cycle t+1.
    logic        sram_fire;
    logic [31:0] sram_pc;
    always begin
        @(negedge clk);
        sram_fire = rst && io.req_valid && io.req_ready;
        sram_pc   = io.req_pc;
        if (sram_fire) fire_cnt++;
        @(posedge clk);
        #1;
        io.inst_sram_rdata = sram_fire ? sram_word(sram_pc) : $urandom();
    end

    // Reference model: an ordered list of delivered entries plus at most one fetch in flight.
    logic [ENT_W-1:0] exp_q[$];
    logic             pend = 1'b0;
    logic [31:0]      pend_pc = '0;

    always @(negedge clk) begin
        logic             exp_rdy;
        logic             exp_valid;
        logic [ENT_W-1:0] head;
        logic             adel;
        if (!rst) begin
            exp_q.delete();
            pend = 1'b0;
        end
        exp_rdy   = rst && !flush && ((exp_q.size() + int'(pend)) < DEPTH);
        exp_valid = exp_q.size() != 0;
        head      = exp_valid ? exp_q[0] : '0;
        check("m_out_valid", io.out_valid, exp_valid);
        check("m_out_adel",  io.out_adel,  head[64]);
        check("m_out_pc",    io.out_pc,    head[63:32]);
        check("m_out_inst",  io.out_inst,  head[31:0]);
        check("m_count",     count,        exp_q.size());
        check("m_req_ready", io.req_ready, exp_rdy);
        if (rst) begin
            if (flush) begin
                exp_q.delete();
                pend = 1'b0;
            end else begin
                if (exp_valid && io.out_ready) void'(exp_q.pop_front());
                if (pend) begin
                    check("m_no_push_full", exp_q.size() < DEPTH, 1);
                    adel = pend_pc[1:0] != 2'b00;
                    exp_q.push_back({adel, pend_pc, adel ? 32'h0 : io.inst_sram_rdata});
                end
                pend    = io.req_valid && exp_rdy;
                pend_pc = io.req_pc;
            end
        end
    end

    typedef struct {
        logic             req_valid;
        logic [31:0]      req_pc;
        logic             out_ready;
        logic             exp_valid;
        logic [31:0]      exp_pc;
        logic [CNT_W-1:0] exp_count;
        logic             exp_rdy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          accepts;
        int          n;
        logic [31:0] pc;
        logic [31:0] exp_inst;

        tbl[0] = '{1'b1, BASE,          1'b1, 1'b0, 32'h0,         3'd0, 1'b1};
        tbl[1] = '{1'b1, BASE + 32'h04, 1'b1, 1'b0, 32'h0,         3'd0, 1'b1};
        tbl[2] = '{1'b1, BASE + 32'h08, 1'b1, 1'b1, BASE,          3'd1, 1'b1};
        tbl[3] = '{1'b1, BASE + 32'h0C, 1'b1, 1'b1, BASE + 32'h04, 3'd1, 1'b1};
        tbl[4] = '{1'b1, BASE + 32'h10, 1'b1, 1'b1, BASE + 32'h08, 3'd1, 1'b1};
        tbl[5] = '{1'b1, BASE + 32'h14, 1'b1, 1'b1, BASE + 32'h0C, 3'd1, 1'b1};
        tbl[6] = '{1'b0, 32'h0,         1'b1, 1'b1, BASE + 32'h10, 3'd1, 1'b1};
        tbl[7] = '{1'b0, 32'h0,         1'b1, 1'b1, BASE + 32'h14, 3'd1, 1'b1};
        tbl[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 1'b1};

        io.req_valid = 1'b0;
        io.req_pc = '0;
        io.out_ready = 1'b0;
        io.inst_sram_rdata = '0;

        // reset state
        @(negedge clk);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_count", count, 0);
        check("rst_req_ready", io.req_ready, 0);
        next_cycle();
        rst = 1'b1;

        // back-to-back fetch with ID always ready
        for (int i = 0; i < 9; i++) begin
            io.req_valid = tbl[i].req_valid;
            io.req_pc    = tbl[i].req_pc;
            io.out_ready = tbl[i].out_ready;
            @(negedge clk);
            exp_inst = tbl[i].exp_valid ? sram_word(tbl[i].exp_pc) : 32'h0;
            check($sformatf("tbl%0d_valid", i), io.out_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d_pc", i), io.out_pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d_inst", i), io.out_inst, exp_inst);
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
            check($sformatf("tbl%0d_ready", i), io.req_ready, tbl[i].exp_rdy);
            next_cycle();
        end

        // credit exhaustion with ID stalled
        io.out_ready = 1'b0;
        io.req_valid = 1'b1;
        pc = 32'h8000_0000;
        @(negedge clk);
        accepts = fire_cnt;
        for (int i = 0; i < 8; i++) begin
            io.req_pc = pc;
            pc += 4;
            next_cycle();
            @(negedge clk);
        end
        check("credit_count", count, DEPTH);
        check("credit_ready", io.req_ready, 0);
        check("credit_accepts", fire_cnt - accepts, DEPTH);
        next_cycle();
        io.req_valid = 1'b0;
        io.out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (count != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("credit_drained", count, 0);
        check("credit_ready_back", io.req_ready, 1);
        next_cycle();

        // flush with three stored entries and one response in flight
        io.out_ready = 1'b0;
        io.req_valid = 1'b1;
        pc = 32'h8000_0040;
        for (int i = 0; i < 4; i++) begin
            io.req_pc = pc;
            pc += 4;
            next_cycle();
        end
        io.req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_pre_count", count, 3);
        check("flush_ready_low", io.req_ready, 0);
        next_cycle();
        flush = 1'b0;
        io.req_valid = 1'b1;
        io.req_pc = 32'h8000_0100;
        @(negedge clk);
        check("flush_post_count", count, 0);
        check("flush_post_valid", io.out_valid, 0);
        check("flush_post_ready", io.req_ready, 1);
        next_cycle();
        io.req_valid = 1'b0;
        io.out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        check("flush_next_valid", io.out_valid, 1);
        check("flush_next_pc", io.out_pc, 32'h8000_0100);
        repeat (3) next_cycle();

        // misaligned fetch followed by an aligned one
        io.req_valid = 1'b1;
        io.req_pc = 32'h8000_0002;
        next_cycle();
        io.req_pc = 32'h8000_0004;
        next_cycle();
        io.req_valid = 1'b0;
        @(negedge clk);
        check("adel_valid", io.out_valid, 1);
        check("adel_flag", io.out_adel, 1);
        check("adel_inst", io.out_inst, 0);
        check("adel_pc", io.out_pc, 32'h8000_0002);
        next_cycle();
        @(negedge clk);
        check("aligned_flag", io.out_adel, 0);
        check("aligned_pc", io.out_pc, 32'h8000_0004);
        check("aligned_inst", io.out_inst, sram_word(32'h8000_0004));
        next_cycle();

        // random traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            pc = $urandom();
            if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
            io.req_valid = $urandom_range(0, 3) != 0;
            io.req_pc    = pc;
            io.out_ready = $urandom_range(0, 2) != 0;
            flush        = $urandom_range(0, 19) == 0;
            next_cycle();
        end
        flush = 1'b0;
        io.req_valid = 1'b0;
        io.out_ready = 1'b1;
        repeat (8) next_cycle();

        // reset mid-stream with two entries stored and one pending
        io.out_ready = 1'b0;
        io.req_valid = 1'b1;
        pc = 32'h8000_0200;
        for (int i = 0; i < 3; i++) begin
            io.req_pc = pc;
            pc += 4;
            next_cycle();
        end
        io.req_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_count", count, 2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", io.out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", io.req_ready, 0);
        check("mid_rst_pc", io.out_pc, 0);
        check("mid_rst_inst", io.out_inst, 0);
        repeat (2) next_cycle();
        rst = 1'b1;
        io.req_valid = 1'b1;
        io.req_pc = 32'h8000_0300;
        io.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", io.req_ready, 1);
        check("post_rst_t0_valid", io.out_valid, 0);
        next_cycle();
        io.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_t1_valid", io.out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("post_rst_t2_valid", io.out_valid, 1);
        check("post_rst_t2_pc", io.out_pc, 32'h8000_0300);
        check("post_rst_t2_inst", io.out_inst, sram_word(32'h8000_0300));
        next_cycle();
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling buffer between IF and ID in the 5-stage MIPS pipeline.
- Replaces the direct IF-to-ID bus plus inst_sram_rdata path with a DEPTH-entry FIFO of {pc, inst, adel} entries.
- Issues credit-limited fetch requests to the synchronous instruction SRAM, captures responses, and presents them in order to ID.
- Supports pipeline flush (exception/branch redirect) and tags misaligned fetch PCs with an address-error flag.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
PC_W, 32, fetch PC width
INST_W, 32, instruction word width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush from CTRL; clears queue and in-flight request
req_valid  in  1  IF presents a fetch PC this cycle
req_pc  in  PC_W  fetch PC
req_ready  out  1  fetch accepted (drives inst_sram_en qualification in IF)
inst_sram_rdata  in  INST_W  SRAM data, valid exactly 1 cycle after an accepted request
out_valid  out  1  head entry valid to ID
out_ready  in  1  ID consumes head (low while ID stalled)
out_pc  out  PC_W  head PC; 0 when out_valid=0
out_inst  out  INST_W  head instruction; 0 when out_valid=0 or out_adel=1
out_adel  out  1  head PC misaligned (pc[1:0]!=0); 0 when out_valid=0
count  out  $clog2(DEPTH+1)  entries currently stored

Behaviour:
- Reset (rst=0, async), all cleared:
  - Clears wr_ptr, rd_ptr, count, rsp_pending and rsp_pc.
  - Outputs: out_valid=0, out_pc=0, out_inst=0, out_adel=0, count=0, req_ready=0 while reset is asserted.
  - Storage array contents need not be reset; outputs are masked.
- Request accept: req_fire = req_valid & req_ready.
  - req_ready = !flush & ((count + rsp_pending) < DEPTH).
  - Entry space is reserved at accept, so a response never finds the queue full.
- Response stage: on req_fire, next cycle rsp_pending=1 and rsp_pc=req_pc. Otherwise rsp_pending=0.
- Enqueue: in the cycle rsp_pending=1 and flush=0, write {rsp_pc, inst_sram_rdata, rsp_pc[1:0]!=0} at wr_ptr, then increment wr_ptr.
  - For adel entries, store inst as 0.
- Back-to-back: one request per cycle is sustained while credit remains. The response and a new accept may occur in the same cycle.
- Latency: request accepted at cycle t -> SRAM data at t+1 -> entry visible on out_* at t+2. There is no bypass.
- Dequeue: pop = out_valid & out_ready. It increments rd_ptr. out_valid = (count != 0).
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
  - Pop when empty cannot occur (out_valid=0).
  - Push when full cannot occur (credit rule). The bench asserts both.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Flush (synchronous, priority over push/pop/accept):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, rsp_pending=0.
  - Any response arriving in the flush cycle is discarded.
  - req_ready=0 during the flush cycle.
  - The first new request can be accepted the cycle after flush deasserts.
- Reset asserted mid-operation aborts everything immediately. After release the block behaves as after power-up. Reset dominates flush.
- Outputs are combinational from head entry and count. No combinational path exists from req_valid to out_*; out_ready affects only state.

Test Plan:
- Reset then 6 consecutive requests (PC 0xBFC00000 step 4, SRAM returns PC^0xFFFF0000), out_ready=1 -> first out_valid at cycle t+2, entries in order, count never exceeds 2, req_ready stays 1.
- out_ready=0 with continuous req_valid, DEPTH=4 -> exactly 4 requests accepted, req_ready drops once count+rsp_pending=4, count=4. Raise out_ready -> 4 pops in order, then req_ready returns 1.
- Fill 3 entries plus 1 pending, assert flush 1 cycle -> pending response dropped, next cycle count=0 and out_valid=0. Request PC 0x80000100 -> it is the next entry out.
- Request PC 0x80000002 -> out_adel=1, out_inst=0, out_pc=0x80000002. Following aligned entry has adel=0.
- Drive >DEPTH*3 push/pop cycles with random out_ready -> pointers wrap, output sequence matches request order, count equals scoreboard depth every cycle.
- Assert rst low mid-stream with count=2 and pending=1 -> outputs immediately 0. After release, first request completes with normal 2-cycle latency and no stale data.
